sparse_pe_stream: RTL

Streaming, lane-parallel successor to the sparse-CNN processing element. Holds one channel's nonzero kernel weights (value, row, col) in a local buffer, then accepts LANES nonzero feature pixels per beat and emits their Cartesian product with every stored weight, one weight per cycle, with output coordinates computed as feature minus weight. Sits between the sparse feature/weight fetch stage and the scatter-accumulate stage. Valid/ready handshakes replace flat whole-image buses.

---
 rtl/sparse_pe_stream_if.sv | 41 ++++
 rtl/sparse_pe_stream.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sparse_pe_stream_if.sv
// Handshake bundle for sparse_pe_stream: weight load, feature beat and product streams.
// slave is the processing-element side, master is the producer/consumer side.
`timescale 1ns/1ps
interface sparse_pe_stream_if #(
   parameter int LANES              = 4,
   parameter int word_length        = 8,
   parameter int col_length         = 8,
   parameter int double_word_length = 16
) ();
   logic                              w_valid, w_ready, w_last;
   logic [word_length-1:0]            w_value;
   logic [col_length-1:0]             w_row, w_col;

   logic                              f_valid, f_ready, f_last;
   logic [LANES-1:0]                  f_mask;
   logic [LANES*word_length-1:0]      f_value;
   logic [LANES*col_length-1:0]       f_rows, f_cols;
   logic [double_word_length-1:0]     f_channel;

   logic                              o_valid, o_ready, o_last;
   logic [LANES-1:0]                  o_mask;
   logic [LANES*2*word_length-1:0]    o_data;
   logic [LANES*col_length-1:0]       o_rows, o_cols;
   logic [double_word_length-1:0]     o_channel;

   modport slave (
      input  w_valid, w_last, w_value, w_row, w_col,
      input  f_valid, f_last, f_mask, f_value, f_rows, f_cols, f_channel,
      input  o_ready,
      output w_ready, f_ready,
      output o_valid, o_mask, o_data, o_rows, o_cols, o_channel, o_last
   );

   modport master (
      output w_valid, w_last, w_value, w_row, w_col,
      output f_valid, f_last, f_mask, f_value, f_rows, f_cols, f_channel,
      output o_ready,
      input  w_ready, f_ready,
      input  o_valid, o_mask, o_data, o_rows, o_cols, o_channel, o_last
   );
endinterface

// File: rtl/sparse_pe_stream.sv
// Streaming sparse PE: buffers one channel's weights, then emits feature x weight products lane-parallel.
// Optional macro SPARSE_PE_BOUNDS_EN masks lanes whose output coordinate falls outside the output map.
`timescale 1ns/1ps
module sparse_pe_stream #(
   parameter int LANES              = 4,
   parameter int word_length        = 8,
   parameter int col_length         = 8,
   parameter int kernel_size        = 5,
   parameter int image_size         = 28,
   parameter int WDEPTH             = 32,
   parameter int double_word_length = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   sparse_pe_stream_if.slave     bus,
   output logic                  busy
);
   localparam int OUT_SIZE = image_size - kernel_size + 1;
   localparam int PW       = 2 * word_length;
   localparam int WCW      = $clog2(WDEPTH + 1);
   localparam int WIW      = $clog2(WDEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, FEAT, COMPUTE} state_t;

   state_t                          state_q, state_d;
   logic [WCW-1:0]                  wcount_q, wcount_d;
   logic [WIW-1:0]                  widx_q, widx_d;
   logic                            o_valid_q, o_valid_d, o_last_q, o_last_d;
   logic [LANES-1:0]                o_mask_q, o_mask_d;
   logic [LANES*PW-1:0]             o_data_q, o_data_d;
   logic [LANES*col_length-1:0]     o_rows_q, o_rows_d, o_cols_q, o_cols_d;
   logic [double_word_length-1:0]   o_channel_q, o_channel_d;

   logic [LANES-1:0]                f_mask_q, f_mask_d;
   logic [LANES*word_length-1:0]    f_value_q, f_value_d;
   logic [LANES*col_length-1:0]     f_rows_q, f_rows_d, f_cols_q, f_cols_d;
   logic [double_word_length-1:0]   f_channel_q, f_channel_d;
   logic                            f_last_q, f_last_d;

   logic signed [word_length-1:0]   wbuf_val [WDEPTH];
   logic [col_length-1:0]           wbuf_row [WDEPTH];
   logic [col_length-1:0]           wbuf_col [WDEPTH];

   logic                            w_hs, f_hs, advance, last_w;
   logic [LANES-1:0]                lane_mask;
   logic [LANES*PW-1:0]             lane_data;
   logic [LANES*col_length-1:0]     lane_rows, lane_cols;

   function automatic logic signed [PW-1:0] lane_mul(input logic signed [word_length-1:0] a,
                                                      input logic signed [word_length-1:0] b);
      logic signed [PW-1:0] ax, bx;
      ax = a;
      bx = b;
      return ax * bx;
   endfunction

`ifdef SPARSE_PE_BOUNDS_EN
   function automatic logic in_map(input logic signed [col_length-1:0] c);
      return !c[col_length-1] && (c <= $signed(col_length'(OUT_SIZE - 1)));
   endfunction
`endif

   assign bus.w_ready = ((state_q == IDLE) || (state_q == LOAD)) && (wcount_q < WCW'(WDEPTH));
   assign bus.f_ready = (state_q == FEAT);
   assign w_hs        = bus.w_valid && bus.w_ready;
   assign f_hs        = bus.f_valid && bus.f_ready;
   assign advance     = (state_q == COMPUTE) && (!o_valid_q || bus.o_ready);
   assign last_w      = (WCW'(widx_q) == wcount_q - WCW'(1));
   assign busy        = (state_q != IDLE);

   assign bus.o_valid   = o_valid_q;
   assign bus.o_mask    = o_mask_q;
   assign bus.o_data    = o_data_q;
   assign bus.o_rows    = o_rows_q;
   assign bus.o_cols    = o_cols_q;
   assign bus.o_channel = o_channel_q;
   assign bus.o_last    = o_last_q;

   // Per-lane product and coordinate difference against the currently indexed weight.
   always_comb begin
      logic signed [PW-1:0]         prod;
      logic signed [col_length-1:0] row, col;
      logic                         keep;
      lane_mask = '0;
      lane_data = '0;
      lane_rows = '0;
      lane_cols = '0;
      prod = '0;
      row  = '0;
      col  = '0;
      keep = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         prod = lane_mul(f_value_q[i*word_length +: word_length], wbuf_val[widx_q]);
         row  = f_rows_q[i*col_length +: col_length] - wbuf_row[widx_q];
         col  = f_cols_q[i*col_length +: col_length] - wbuf_col[widx_q];
         keep = f_mask_q[i];
`ifdef SPARSE_PE_BOUNDS_EN
         keep = keep && in_map(row) && in_map(col);
`endif
         lane_mask[i]                           = keep;
         lane_data[i*PW +: PW]                  = keep ? prod : '0;
         lane_rows[i*col_length +: col_length]  = keep ? row  : '0;
         lane_cols[i*col_length +: col_length]  = keep ? col  : '0;
      end
   end

   always_comb begin
      state_d     = state_q;
      wcount_d    = wcount_q;
      widx_d      = widx_q;
      o_valid_d   = o_valid_q;
      o_mask_d    = o_mask_q;
      o_data_d    = o_data_q;
      o_rows_d    = o_rows_q;
      o_cols_d    = o_cols_q;
      o_channel_d = o_channel_q;
      o_last_d    = o_last_q;
      f_mask_d    = f_mask_q;
      f_value_d   = f_value_q;
      f_rows_d    = f_rows_q;
      f_cols_d    = f_cols_q;
      f_channel_d = f_channel_q;
      f_last_d    = f_last_q;

      if (o_valid_q && bus.o_ready) o_valid_d = 1'b0;

      if (w_hs) begin
         wcount_d = wcount_q + WCW'(1);
         state_d  = LOAD;
         if (bus.w_last || (wcount_q == WCW'(WDEPTH - 1))) state_d = FEAT;
      end

      if (f_hs) begin
         f_mask_d    = bus.f_mask;
         f_value_d   = bus.f_value;
         f_rows_d    = bus.f_rows;
         f_cols_d    = bus.f_cols;
         f_channel_d = bus.f_channel;
         f_last_d    = bus.f_last;
         widx_d      = '0;
         state_d     = COMPUTE;
      end

      // The output register refills only when empty or being drained, so a stall freezes widx.
      if (advance) begin
         o_valid_d   = 1'b1;
         o_mask_d    = lane_mask;
         o_data_d    = lane_data;
         o_rows_d    = lane_rows;
         o_cols_d    = lane_cols;
         o_channel_d = f_channel_q;
         o_last_d    = last_w && f_last_q;
         widx_d      = widx_q + WIW'(1);
         if (last_w) begin
            if (f_last_q) begin
               state_d  = IDLE;
               wcount_d = '0;
            end else begin
               state_d  = FEAT;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         wcount_q    <= '0;
         widx_q      <= '0;
         o_valid_q   <= 1'b0;
         o_mask_q    <= '0;
         o_data_q    <= '0;
         o_rows_q    <= '0;
         o_cols_q    <= '0;
         o_channel_q <= '0;
         o_last_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         wcount_q    <= wcount_d;
         widx_q      <= widx_d;
         o_valid_q   <= o_valid_d;
         o_mask_q    <= o_mask_d;
         o_data_q    <= o_data_d;
         o_rows_q    <= o_rows_d;
         o_cols_q    <= o_cols_d;
         o_channel_q <= o_channel_d;
         o_last_q    <= o_last_d;
      end
   end

   always_ff @(posedge clk) begin
      f_mask_q    <= f_mask_d;
      f_value_q   <= f_value_d;
      f_rows_q    <= f_rows_d;
      f_cols_q    <= f_cols_d;
      f_channel_q <= f_channel_d;
      f_last_q    <= f_last_d;
      if (w_hs) begin
         wbuf_val[wcount_q[WIW-1:0]] <= bus.w_value;
         wbuf_row[wcount_q[WIW-1:0]] <= bus.w_row;
         wbuf_col[wcount_q[WIW-1:0]] <= bus.w_col;
      end
   end
endmodule
